// File: rtl/sched_pkg.sv
// Shared types and sizing for the sample scheduler.
// Holds the FSM state type, widths and the WAIT timeout length.
package sched_pkg;

    localparam int unsigned NUM_VOICES  = 4;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned MIX_W       = 10;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned IDX_W       = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StWait,
        StDone
    } sched_state_e;

    function automatic logic [NUM_VOICES-1:0] voice_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_VOICES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sched_timeout_counter.sv
// Counts consecutive cycles while clear is low.
// expired is raised during the TIMEOUT_CYC-th such cycle.
module sched_timeout_counter
    import sched_pkg::*;
(
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = clear ? '0 : cnt_q + CNT_W'(1);
        expired = !clear && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Per-sample voice fetch scheduler: walks the active voices, sums their samples, publishes mix.
// Optional WAIT timeout is enabled by defining SCHED_TIMEOUT_EN.
module sample_scheduler
    import sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  enable,
    output logic                  div_enable,
    input  logic                  sample_now,
    input  logic [NUM_VOICES-1:0] voice_active,
    output logic [NUM_VOICES-1:0] voice_req,
    input  logic [NUM_VOICES-1:0] voice_ack,
    input  logic [SAMPLE_W-1:0]   voice_sample,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic                  overrun
);

    sched_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [MIX_W-1:0]      acc_q, acc_d;
    logic [NUM_VOICES-1:0] voice_req_q, voice_req_d;
    logic [MIX_W-1:0]      mix_out_q, mix_out_d;
    logic                  mix_valid_q, mix_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  is_last;
    logic                  wait_expired;

`ifdef SCHED_TIMEOUT_EN
    logic timeout_clear;

    assign timeout_clear = (state_q != StWait) || !enable;

    sched_timeout_counter u_timeout (
        .clk     (clk),
        .nRst    (nRst),
        .clear   (timeout_clear),
        .expired (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    assign is_last = (idx_q == IDX_W'(NUM_VOICES - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        voice_req_d = voice_req_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (!enable) begin
            state_d     = StIdle;
            voice_req_d = '0;
            overrun_d   = 1'b0;
        end else begin
            // A strobe outside IDLE (including DONE) is flagged, never restarts the scan.
            if (sample_now && (state_q != StIdle)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (sample_now) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = StScan;
                    end
                end
                StScan: begin
                    if (voice_active[idx_q]) begin
                        voice_req_d = voice_onehot(idx_q);
                        state_d     = StWait;
                    end else if (is_last) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                StWait: begin
                    // A timed-out voice contributes nothing but is otherwise treated as acked.
                    if (voice_ack[idx_q] || wait_expired) begin
                        if (voice_ack[idx_q]) begin
                            acc_d = acc_q + MIX_W'(voice_sample);
                        end
                        voice_req_d = '0;
                        if (is_last) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StScan;
                        end
                    end
                end
                StDone: begin
                    mix_out_d   = acc_q;
                    mix_valid_d = 1'b1;
                    state_d     = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            voice_req_q <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            voice_req_q <= voice_req_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign div_enable = enable;
    assign voice_req  = voice_req_q;
    assign mix_out    = mix_out_q;
    assign mix_valid  = mix_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: nRst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: enable  in  1  run enable.
REQ-004 SHALL have port: div_enable  out  1  enable to the sample-rate divider; combinationally equal to enable.
REQ-005 SHALL have port: sample_now  in  1  one-cycle sample strobe from the divider.
REQ-006 SHALL have port: voice_active  in  4  per-voice gate; 1 = voice contributes this sample.
REQ-007 SHALL have port: voice_req  out  4  one-hot request to the voice being fetched; registered.
REQ-008 SHALL have port: voice_ack  in  4  per-voice acknowledge.
REQ-009 SHALL have port: voice_sample  in  8  unsigned sample; valid when the requested voice's ack is high.
REQ-010 SHALL have port: mix_out  out  10  unsigned sum of fetched samples; registered.
REQ-011 SHALL have port: mix_valid  out  1  one-cycle pulse when mix_out updates.
REQ-012 SHALL have port: overrun  out  1  sticky flag: strobe arrived while busy.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, WAIT, DONE.
REQ-014 IDLE: on enable & sample_now -> clear accumulator, idx=0, go SCAN. Otherwise stay in IDLE.
REQ-015 SCAN: if voice_active[idx] -> set voice_req = 1<<idx, go WAIT. Else skip the voice: idx+1, or go DONE when idx==3.
REQ-016 WAIT: hold voice_req until voice_ack[idx]=1. On ack: acc += voice_sample, clear voice_req at the same edge, then idx+1 -> SCAN, or DONE when idx==3.
REQ-017 Acks on non-requested lines SHALL be ignored.
REQ-018 Accumulator SHALL be 10 bits; maximum 4*255=1020, so no wrap occurs.
REQ-019 DONE: at the next edge, mix_out <= acc, mix_valid=1 for exactly that cycle, go IDLE.
REQ-020 Latency: inactive voice = 1 cycle (SCAN); active voice with immediate ack = 2 cycles (SCAN+WAIT).
REQ-021 sample_now seen in any state other than IDLE SHALL set overrun and SHALL NOT restart the scan; this includes the DONE cycle.
REQ-022 enable=0 in any state SHALL force IDLE at the next edge, clear voice_req, suppress mix_valid, hold mix_out, and clear overrun.
REQ-023 sample_now while enable=0 SHALL be ignored.

Reset
REQ-024 nRst=0 SHALL asynchronously force: state=IDLE, idx=0, acc=0, voice_req=0, mix_out=0, mix_valid=0, overrun=0.
REQ-025 Reset mid-scan SHALL abort the scan with no mix_valid; operation resumes on the first strobe after nRst=1.

Configuration
REQ-026 Macro SCHED_TIMEOUT_EN, when defined: a WAIT lasting 16 cycles without ack SHALL drop voice_req, add 0 for that voice, and continue as if acked.
REQ-027 Without SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, and no timeout counter logic SHALL exist.

Structure
REQ-028 Package sched_pkg SHALL hold: the state enum typedef, NUM_VOICES=4, SAMPLE_W=8, MIX_W=10, TIMEOUT_CYC=16.
REQ-029 The timeout counter SHALL be sub-module sched_timeout_counter (clk, nRst, clear, expired), instantiated only under SCHED_TIMEOUT_EN.

Verification
REQ-030 voice_active=0000, single sample_now -> no voice_req ever; mix_valid pulse 6 cycles after the strobe edge with mix_out=0.
REQ-031 voice_active=1111, acks immediate, samples 255 each -> voice_req walks 0001,0010,0100,1000; mix_out=1020; mix_valid once.
REQ-032 voice_active=0101, samples 10 and 20, ack on voice 2 delayed 5 cycles -> mix_out=30; voice_req=0100 held 5 cycles.
REQ-033 Second sample_now mid-scan -> overrun=1 and stays 1; the scan completes with the correct sum; a single mix_valid.
REQ-034 enable dropped during WAIT -> voice_req=0 and state IDLE next cycle; no mix_valid; mix_out unchanged; overrun cleared.
REQ-035 With SCHED_TIMEOUT_EN defined, voice 0 never acks, voice 1 sample=7 -> voice 0 released after 16 cycles; mix_out=7.
